xadc_pwm_scanner: RTL
=====================

XADC_PWM_SCANNER -- requirements
Module: xadc_pwm_scanner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 4, channel count, legal range 1..8
- CH_ADDRS, {7'h16,7'h1F,7'h17,7'h1E}, packed DRP addresses; channel i uses bits [7i+6:7i]
- PWM_BITS, 8, PWM counter and duty width, legal range 4..12
- AVG_LOG2, 0, log2 of conversions averaged per channel visit, legal range 0..4
- TIMEOUT, 255, maximum cycles waiting for drdy, legal range 1..65535

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, asynchronous active-high reset
- eoc, in, 1, XADC end-of-conversion pulse
- drdy, in, 1, DRP data ready
- dout, in, 16, DRP read data; 12-bit result left-justified
- ch_en, in, NUM_CH, per-channel enable mask
- err_clr, in, 1, clears err_timeout
- den, out, 1, DRP enable strobe
- dwe, out, 1, DRP write enable
- daddr, out, 7, DRP address
- led, out, NUM_CH, PWM outputs
- sample_valid, out, 1, one-cycle new-result strobe
- sample_ch, out, 3, channel index of the result
- sample_data, out, PWM_BITS, averaged result
- err_timeout, out, 1, sticky DRP timeout flag

REQ-003 The block SHALL use one clock domain, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT.
- IDLE->REQ: on eoc=1 with ch_en nonzero.
- REQ->WAIT: unconditionally after one cycle.
- WAIT->IDLE: on drdy=1 or on timeout.
REQ-005 In REQ, den SHALL be 1 for exactly one cycle; in all other states den SHALL be 0; dwe SHALL be constant 0.
REQ-006 daddr SHALL equal the CH_ADDRS entry of the current channel index in every state.
REQ-007 eoc SHALL be ignored in REQ and WAIT; drdy SHALL be ignored in IDLE and REQ.
REQ-008 On drdy in WAIT:
- the block SHALL add dout[15:4] to a (12+AVG_LOG2)-bit accumulator and increment a visit counter.
- When the counter reaches 2^AVG_LOG2, the stored result SHALL be the top PWM_BITS bits of (accumulator >> AVG_LOG2), truncated.
- The accumulator and counter SHALL then clear and the channel index SHALL advance.
REQ-009 The result register of the channel SHALL update in the cycle after the final drdy. In that same cycle, sample_valid=1, sample_ch=index, and sample_data=result.
REQ-010 Advance SHALL select the next enabled channel above the current index, wrapping to 0, using ch_en sampled at advance time. If no channel is enabled, the index SHALL hold.
REQ-011 If the current channel becomes disabled mid-visit, the visit SHALL complete normally.
REQ-012 With ch_en all zero in IDLE, no den SHALL be issued.
REQ-013 Timeout: if drdy does not arrive within TIMEOUT cycles of entering WAIT:
- err_timeout SHALL set;
- the partial accumulation SHALL be discarded, with no sample_valid;
- the index SHALL advance;
- the FSM SHALL return to IDLE.
REQ-014 err_clr SHALL clear err_timeout; if err_clr and a timeout coincide, set SHALL win.
REQ-015 PWM counter and duty:
- A shared PWM_BITS-bit counter SHALL increment every cycle and wrap from all-ones to 0.
- Each duty register SHALL load from its channel result only on the cycle the counter equals 0.
REQ-016 led[i] SHALL be (counter < duty[i]) AND ch_en[i], registered.
- duty 0 SHALL give LED always off.
- duty all-ones SHALL give 2^PWM_BITS-1 on-cycles per period.

Reset
REQ-017 While rst=1, the block SHALL hold:
- FSM in IDLE, index 0, daddr=CH_ADDRS[6:0];
- den, dwe, led, sample_valid, err_timeout = 0;
- sample_ch, sample_data = 0;
- accumulator, visit counter, results, duties, PWM counter = 0.
REQ-018 Reset asserted mid-transaction SHALL abort it immediately. A drdy arriving after release SHALL be ignored, since the FSM is in IDLE.
REQ-019 After rst deasserts, the first den SHALL occur one cycle after the first eoc.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Defaults, ch_en=4'hF, eoc pulses, drdy 3 cycles after den with dout=16'hA5F0 -> daddr sequence 1E,17,1F,16; sample_data=8'hA5 for each channel; led duty 165/256 after next wrap.
- AVG_LOG2=2, four conversions on channel 0 with dout[15:4]=12'h100,12'h200,12'h300,12'h400 -> exactly one sample_valid; sample_data=8'h28.
- No drdy for 255 cycles after den -> err_timeout=1, no sample_valid, index advances; err_clr pulse -> err_timeout=0.
- ch_en=4'b0101 -> requests alternate channels 0,2; led[1]=led[3]=0; ch_en=0 -> no den despite eoc.
- Result changes mid-PWM-period -> led duty changes only after counter wraps to 0; dout=16'h0000 -> led stays 0.
- rst asserted while in WAIT, drdy after release -> no sample_valid; all outputs at reset values.

Source files
------------

// File: rtl/xadc_pwm_scanner.sv
// XADC DRP channel scanner: reads one channel per eoc, averages, and drives
// a per-channel PWM LED whose duty follows the latest averaged result.

module xadc_pwm_lane #(
  parameter int PWM_BITS = 8
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] res,
  input  logic                en,
  output logic                led
);
  logic [PWM_BITS-1:0] duty;

  // duty reloads only at the period boundary so a period is never torn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (cnt == '0) duty <= res;
      led <= (cnt < duty) && en;
    end
  end
endmodule

module xadc_pwm_scanner #(
  parameter int                  NUM_CH   = 4,
  parameter logic [7*NUM_CH-1:0] CH_ADDRS = {7'h16, 7'h1F, 7'h17, 7'h1E},
  parameter int                  PWM_BITS = 8,
  parameter int                  AVG_LOG2 = 0,
  parameter int                  TIMEOUT  = 255
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                eoc,
  input  logic                drdy,
  input  logic [15:0]         dout,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                err_clr,
  output logic                den,
  output logic                dwe,
  output logic [6:0]          daddr,
  output logic [NUM_CH-1:0]   led,
  output logic                sample_valid,
  output logic [2:0]          sample_ch,
  output logic [PWM_BITS-1:0] sample_data,
  output logic                err_timeout
);
  localparam int AW   = 12 + AVG_LOG2;
  localparam int CW   = AVG_LOG2 + 1;
  localparam int NAVG = 1 << AVG_LOG2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                           state;
  logic [2:0]                       idx, nxt;
  logic [AW-1:0]                    acc, sum;
  logic [CW-1:0]                    vcnt, vcnt_n;
  logic [15:0]                      tcnt;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  res;
  logic [PWM_BITS-1:0]              pwm_cnt, avg_top;
  logic                             unused_dout;

  // Nearest enabled channel strictly above cur (wrapping); cur itself only
  // if it is the sole enabled one; hold when nothing is enabled.
  function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic [NUM_CH-1:0] en);
    logic [2:0] r;
    int         best, d;
    r    = cur;
    best = NUM_CH + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      d = (c - int'(cur) + NUM_CH) % NUM_CH;
      if (d == 0) d = NUM_CH;
      if (en[c] && d < best) begin
        best = d;
        r    = 3'(c);
      end
    end
    return r;
  endfunction

  assign dwe         = 1'b0;
  assign unused_dout = ^dout[3:0];
  assign sum         = acc + AW'(dout[15:4]);
  assign vcnt_n      = vcnt + CW'(1);
  assign avg_top     = sum[AVG_LOG2+11 -: PWM_BITS];
  assign nxt         = next_idx(idx, ch_en);

  always_comb begin
    daddr = CH_ADDRS[6:0];
    for (int i = 1; i < NUM_CH; i++)
      if (idx == 3'(i)) daddr = CH_ADDRS[7*i +: 7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      vcnt         <= '0;
      tcnt         <= '0;
      res          <= '0;
      den          <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      den          <= 1'b0;
      sample_valid <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: if (eoc && |ch_en) begin
          state <= REQ;
          den   <= 1'b1;
        end
        REQ: begin
          state <= WAIT;
          tcnt  <= '0;
        end
        WAIT: if (drdy) begin
          state <= IDLE;
          if (vcnt_n == CW'(NAVG)) begin
            for (int i = 0; i < NUM_CH; i++)
              if (idx == 3'(i)) res[i] <= avg_top;
            sample_valid <= 1'b1;
            sample_ch    <= idx;
            sample_data  <= avg_top;
            acc          <= '0;
            vcnt         <= '0;
            idx          <= nxt;
          end else begin
            acc  <= sum;
            vcnt <= vcnt_n;
          end
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          // partial average is dropped; set beats a coincident err_clr
          state       <= IDLE;
          err_timeout <= 1'b1;
          acc         <= '0;
          vcnt        <= '0;
          idx         <= nxt;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    xadc_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk (clk),
      .rst (rst),
      .cnt (pwm_cnt),
      .res (res[g]),
      .en  (ch_en[g]),
      .led (led[g])
    );
  end
endmodule
